// File: rtl/game_pkg.sv
// Shared state encoding, default parameters and background palette for the
// game-level controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    HIT,
    LEVEL_UP,
    WON,
    OVER
  } state_t;

  localparam int NUM_LEVELS_DEF     = 4;
  localparam int LIVES_DEF          = 3;
  localparam int HIT_FRAMES_DEF     = 30;
  localparam int LEVELUP_FRAMES_DEF = 60;
  localparam int FLASH_PERIOD_DEF   = 8;

  // Index 0 is the brightest background; later levels get darker.
  localparam logic [3:0][3:0] BG_LUT = {4'h3, 4'h6, 4'h9, 4'hC};

  // Flash starts dark and toggles every 'period' frames.
  function automatic logic [3:0] flash_bg(input logic [7:0] cnt,
                                          input logic [1:0] level,
                                          input int         period);
    return (((int'(cnt) / period) % 2) == 0) ? 4'h0 : BG_LUT[level];
  endfunction

endpackage

// File: rtl/game_level_ctrl_if.sv
// Link between the game-level controller and color_mapper / ball logic.
interface game_level_ctrl_if;
  logic       collision;
  logic       finish_line_reached;
  logic [1:0] current_level;
  logic [3:0] background;
  logic [3:0] foreground;
  logic       reset_player;

  modport master (
    input  collision, finish_line_reached,
    output current_level, background, foreground, reset_player
  );

  modport slave (
    output collision, finish_line_reached,
    input  current_level, background, foreground, reset_player
  );
endinterface

// File: rtl/frame_sync.sv
// Optional 2-FF synchronizer followed by a registered rising-edge detector.
// With synchronization the pulse lands 3 clocks after the raw edge, bypassed 2.
module frame_sync #(
  parameter bit BYPASS_SYNC = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= BYPASS_SYNC ? async_in : meta;
      prev   <= sync_q;
      pulse  <= sync_q & ~prev;
    end
  end

endmodule

// File: rtl/game_level_ctrl.sv
// Game-state controller: tracks lives and level from per-frame collision and
// finish flags and drives level/palette/player-hold back into the mapper.
module game_level_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS     = NUM_LEVELS_DEF,
  parameter int LIVES          = LIVES_DEF,
  parameter int HIT_FRAMES     = HIT_FRAMES_DEF,
  parameter int LEVELUP_FRAMES = LEVELUP_FRAMES_DEF,
  parameter int FLASH_PERIOD   = FLASH_PERIOD_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               start,
  game_level_ctrl_if.master  mapper,
  output logic [1:0]         lives,
  output logic               game_won,
  output logic               game_over
);

  logic       frame_tick;
  logic       start_pulse;
  state_t     state;
  logic [1:0] level;
  logic [1:0] life_cnt;
  logic [7:0] frame_cnt;

  logic [1:0] level_q;
  logic [3:0] background_q;
  logic [3:0] foreground_q;
  logic       reset_player_q;

  frame_sync #(.BYPASS_SYNC(1'b0)) u_frame_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .pulse    (frame_tick)
  );

  // The start key is already in the Clk domain, so only edge detection is needed.
  frame_sync #(.BYPASS_SYNC(1'b1)) u_start_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (start),
    .pulse    (start_pulse)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      level     <= 2'd0;
      life_cnt  <= 2'(LIVES);
      frame_cnt <= 8'd0;
    end else begin
      if (frame_tick && frame_cnt != 8'hFF)
        frame_cnt <= frame_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (start_pulse) begin
            state     <= PLAY;
            level     <= 2'd0;
            life_cnt  <= 2'(LIVES);
            frame_cnt <= 8'd0;
          end
        end
        // Finish outranks collision so a photo-finish crash costs no life.
        PLAY: begin
          if (frame_tick && mapper.finish_line_reached) begin
            frame_cnt <= 8'd0;
            if (level == 2'(NUM_LEVELS - 1)) begin
              state <= WON;
            end else begin
              state <= LEVEL_UP;
              level <= level + 2'd1;
            end
          end else if (frame_tick && mapper.collision) begin
            frame_cnt <= 8'd0;
            if (life_cnt > 2'd1) begin
              state    <= HIT;
              life_cnt <= life_cnt - 2'd1;
            end else begin
              state    <= OVER;
              life_cnt <= 2'd0;
            end
          end
        end
        HIT: begin
          if (frame_tick && frame_cnt == 8'(HIT_FRAMES - 1)) begin
            state     <= PLAY;
            frame_cnt <= 8'd0;
          end
        end
        LEVEL_UP: begin
          if (frame_tick && frame_cnt == 8'(LEVELUP_FRAMES - 1)) begin
            state     <= PLAY;
            frame_cnt <= 8'd0;
          end
        end
        WON, OVER: begin
          if (start_pulse) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
          end
        end
        default: begin
          state     <= IDLE;
          frame_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Outputs trail the state/counter registers by one clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      level_q        <= 2'd0;
      background_q   <= BG_LUT[0];
      foreground_q   <= 4'h0;
      reset_player_q <= 1'b1;
      lives          <= 2'(LIVES);
      game_won       <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      level_q        <= level;
      lives          <= life_cnt;
      game_won       <= (state == WON);
      game_over      <= (state == OVER);
      reset_player_q <= (state != PLAY);
      foreground_q   <= (state == PLAY) ? 4'hF : 4'h0;
      case (state)
        IDLE:           background_q <= BG_LUT[0];
        HIT, WON, OVER: background_q <= flash_bg(frame_cnt, level, FLASH_PERIOD);
        default:        background_q <= BG_LUT[level];
      endcase
    end
  end

  assign mapper.current_level = level_q;
  assign mapper.background    = background_q;
  assign mapper.foreground    = foreground_q;
  assign mapper.reset_player  = reset_player_q;

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed bench for game_level_ctrl: walks start, hit, level-up, win,
// game-over and mid-countdown reset with hand-computed expectations.
module tb_game_level_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic [1:0] lives;
  logic       game_won;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  game_level_ctrl_if bus ();

  game_level_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .start     (start),
    .mapper    (bus.master),
    .lives     (lives),
    .game_won  (game_won),
    .game_over (game_over)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One video frame: flags held across the tick, 10 clocks total.
  task automatic apply_frame(input logic coll, input logic fin);
    bus.collision           = coll;
    bus.finish_line_reached = fin;
    frame_clk = 1'b1;
    cycles(5);
    frame_clk = 1'b0;
    cycles(5);
    bus.collision           = 1'b0;
    bus.finish_line_reached = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) apply_frame(1'b0, 1'b0);
  endtask

  task automatic press_start();
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(4);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_lives"}, 8'(lives), 8'd3);
    check_output({tag, "_level"}, 8'(bus.current_level), 8'd0);
    check_output({tag, "_bg"}, 8'(bus.background), 8'hC);
    check_output({tag, "_fg"}, 8'(bus.foreground), 8'h0);
    check_output({tag, "_rp"}, 8'(bus.reset_player), 8'd1);
    check_output({tag, "_won"}, 8'(game_won), 8'd0);
    check_output({tag, "_over"}, 8'(game_over), 8'd0);
  endtask

  initial begin
    bus.collision           = 1'b0;
    bus.finish_line_reached = 1'b0;

    cycles(3);
    check_reset_values("reset");
    Reset_n = 1'b1;
    cycles(2);

    apply_frame(1'b1, 1'b0);
    check_output("idle_coll_lives", 8'(lives), 8'd3);
    check_output("idle_rp", 8'(bus.reset_player), 8'd1);

    press_start();
    idle_frames(1);
    check_output("play_rp", 8'(bus.reset_player), 8'd0);
    check_output("play_lives", 8'(lives), 8'd3);
    check_output("play_level", 8'(bus.current_level), 8'd0);
    check_output("play_bg", 8'(bus.background), 8'hC);
    check_output("play_fg", 8'(bus.foreground), 8'hF);

    apply_frame(1'b1, 1'b0);
    check_output("hit_lives", 8'(lives), 8'd2);
    check_output("hit_rp", 8'(bus.reset_player), 8'd1);
    check_output("hit_bg0", 8'(bus.background), 8'h0);
    idle_frames(7);
    check_output("hit_bg7", 8'(bus.background), 8'h0);
    idle_frames(1);
    check_output("hit_bg8", 8'(bus.background), 8'hC);
    idle_frames(8);
    check_output("hit_bg16", 8'(bus.background), 8'h0);
    idle_frames(13);
    check_output("hit_rp29", 8'(bus.reset_player), 8'd1);
    check_output("hit_bg29", 8'(bus.background), 8'hC);
    idle_frames(1);
    check_output("hit_done_rp", 8'(bus.reset_player), 8'd0);
    check_output("hit_done_bg", 8'(bus.background), 8'hC);
    check_output("hit_done_lives", 8'(lives), 8'd2);

    apply_frame(1'b0, 1'b1);
    check_output("lu1_level", 8'(bus.current_level), 8'd1);
    check_output("lu1_bg", 8'(bus.background), 8'h9);
    check_output("lu1_fg", 8'(bus.foreground), 8'h0);
    check_output("lu1_rp", 8'(bus.reset_player), 8'd1);
    idle_frames(59);
    check_output("lu1_rp59", 8'(bus.reset_player), 8'd1);
    idle_frames(1);
    check_output("lu1_done_rp", 8'(bus.reset_player), 8'd0);
    check_output("lu1_done_fg", 8'(bus.foreground), 8'hF);

    apply_frame(1'b1, 1'b1);
    check_output("lu2_level", 8'(bus.current_level), 8'd2);
    check_output("lu2_bg", 8'(bus.background), 8'h6);
    check_output("lu2_lives", 8'(lives), 8'd2);
    idle_frames(60);
    check_output("lu2_done_rp", 8'(bus.reset_player), 8'd0);

    apply_frame(1'b0, 1'b1);
    check_output("lu3_level", 8'(bus.current_level), 8'd3);
    check_output("lu3_bg", 8'(bus.background), 8'h3);
    idle_frames(60);
    check_output("lu3_done_rp", 8'(bus.reset_player), 8'd0);

    apply_frame(1'b0, 1'b1);
    check_output("won", 8'(game_won), 8'd1);
    check_output("won_over", 8'(game_over), 8'd0);
    check_output("won_level", 8'(bus.current_level), 8'd3);
    check_output("won_rp", 8'(bus.reset_player), 8'd1);
    apply_frame(1'b1, 1'b0);
    check_output("won_coll_lives", 8'(lives), 8'd2);

    press_start();
    check_output("won_to_idle", 8'(game_won), 8'd0);
    check_output("won_idle_bg", 8'(bus.background), 8'hC);
    press_start();
    check_output("restart_lives", 8'(lives), 8'd3);
    check_output("restart_level", 8'(bus.current_level), 8'd0);
    check_output("restart_rp", 8'(bus.reset_player), 8'd0);

    apply_frame(1'b1, 1'b0);
    check_output("over_l2", 8'(lives), 8'd2);
    idle_frames(30);
    apply_frame(1'b1, 1'b0);
    check_output("over_l1", 8'(lives), 8'd1);
    idle_frames(30);
    apply_frame(1'b1, 1'b0);
    check_output("over_l0", 8'(lives), 8'd0);
    check_output("over_flag", 8'(game_over), 8'd1);
    check_output("over_won", 8'(game_won), 8'd0);
    check_output("over_rp", 8'(bus.reset_player), 8'd1);
    press_start();
    check_output("over_to_idle", 8'(game_over), 8'd0);
    press_start();
    check_output("over_restart_lives", 8'(lives), 8'd3);
    check_output("over_restart_rp", 8'(bus.reset_player), 8'd0);

    apply_frame(1'b1, 1'b0);
    check_output("mid_hit_lives", 8'(lives), 8'd2);
    idle_frames(10);
    Reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    cycles(3);
    Reset_n = 1'b1;
    cycles(2);
    apply_frame(1'b0, 1'b0);
    check_output("post_reset_rp", 8'(bus.reset_player), 8'd1);
    check_output("post_reset_lives", 8'(lives), 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
